exe_stage_md: RTL and testbench

- Parametrised next-generation execute stage: single-cycle ALU datapath plus an iterative multi-cycle multiply/divide unit owning the HI/LO registers.
- Sits between decode/issue and MEM and registers all pass-through control to MEM.
- Adds valid/ready backpressure, synchronous flush, and a busy FSM so MULT/DIV no longer complete combinationally.

---
 rtl/exe_stage_md.sv | 312 +++++++++++++++++++++++++++++++
 tb/tb_exe_stage_md.sv | 580 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_stage_md.sv
// Execute stage: a single-cycle ALU datapath plus an iterative radix-2
// multiply/divide unit that owns the HI/LO registers. Every field handed to
// MEM is registered here, with valid/ready handshaking and a synchronous flush.
module exe_stage_md #(
    parameter int W     = 32,
    parameter int CNT_W = 6
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             Flush,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [31:0]      Instr_IN,
    input  logic [31:0]      Instr_PC_IN,
    input  logic [W-1:0]     OperandA_IN,
    input  logic [W-1:0]     OperandB_IN,
    input  logic [4:0]       WriteRegister_IN,
    input  logic [W-1:0]     MemWriteData_IN,
    input  logic             RegWrite_IN,
    input  logic             MemRead_IN,
    input  logic             MemWrite_IN,
    input  logic [5:0]       ALU_Control_IN,
    input  logic [4:0]       ShiftAmount_IN,
    output logic             Out_Valid,
    output logic [31:0]      Instr_OUT,
    output logic [31:0]      Instr_PC_OUT,
    output logic [W-1:0]     ALU_result_OUT,
    output logic [4:0]       WriteRegister_OUT,
    output logic [W-1:0]     MemWriteData_OUT,
    output logic             RegWrite_OUT,
    output logic [5:0]       ALU_Control_OUT,
    output logic             MemRead_OUT,
    output logic             MemWrite_OUT,
    output logic             Busy
);

    localparam int SHW = $clog2(W);

    localparam logic [5:0] OP_ADD   = 6'h00;
    localparam logic [5:0] OP_SUB   = 6'h01;
    localparam logic [5:0] OP_AND   = 6'h02;
    localparam logic [5:0] OP_OR    = 6'h03;
    localparam logic [5:0] OP_XOR   = 6'h04;
    localparam logic [5:0] OP_NOR   = 6'h05;
    localparam logic [5:0] OP_SLT   = 6'h06;
    localparam logic [5:0] OP_SLTU  = 6'h07;
    localparam logic [5:0] OP_SLL   = 6'h08;
    localparam logic [5:0] OP_SRL   = 6'h09;
    localparam logic [5:0] OP_SRA   = 6'h0A;
    localparam logic [5:0] OP_LUI   = 6'h0B;
    localparam logic [5:0] OP_MULT  = 6'h10;
    localparam logic [5:0] OP_MULTU = 6'h11;
    localparam logic [5:0] OP_DIV   = 6'h12;
    localparam logic [5:0] OP_DIVU  = 6'h13;
    localparam logic [5:0] OP_MFHI  = 6'h14;
    localparam logic [5:0] OP_MFLO  = 6'h15;
    localparam logic [5:0] OP_MTHI  = 6'h16;
    localparam logic [5:0] OP_MTLO  = 6'h17;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [W-1:0]     hi_q;
    logic [W-1:0]     lo_q;

    // Iteration datapath: accHi_q is one bit wider to hold the add carry /
    // the restoring-divide trial sign; accLo_q is multiplier or dividend.
    logic [W:0]       accHi_q;
    logic [W-1:0]     accLo_q;
    logic [W-1:0]     mcand_q;
    logic             isDiv_q;
    logic             negLo_q;
    logic             negHi_q;
    logic             divZero_q;
    logic [W-1:0]     dividend_q;

    // Instruction bundle held while the MD unit iterates.
    logic [31:0]      bInstr_q;
    logic [31:0]      bPc_q;
    logic [4:0]       bWreg_q;
    logic [W-1:0]     bMemData_q;
    logic             bMemRead_q;
    logic             bMemWrite_q;
    logic [5:0]       bAluCtl_q;

    // Registered outputs toward MEM.
    logic             outValid_q;
    logic [31:0]      instr_q;
    logic [31:0]      pc_q;
    logic [W-1:0]     result_q;
    logic [4:0]       wreg_q;
    logic [W-1:0]     memData_q;
    logic             regWrite_q;
    logic [5:0]       aluCtl_q;
    logic             memRead_q;
    logic             memWrite_q;

    logic             accept;
    logic             isMdOp;
    logic [SHW-1:0]   shamt;
    logic [W-1:0]     aluRes;
    logic             isSignedOp;
    logic             isDivOp;
    logic [W-1:0]     magA;
    logic [W-1:0]     magB;
    logic             negLo;
    logic             negHi;
    logic             divZero;
    logic [W:0]       accHi_d;
    logic [W-1:0]     accLo_d;
    logic [W:0]       mulSum;
    logic [W:0]       divShift;
    logic [W:0]       divTrial;
    logic [2*W-1:0]   prodMag;
    logic [2*W-1:0]   prodRes;
    logic [W-1:0]     finalHi_d;
    logic [W-1:0]     finalLo_d;

    assign In_Ready          = (state_q == IDLE);
    assign Busy              = (state_q == BUSY);
    assign accept            = In_Valid & In_Ready & ~Flush;
    assign isMdOp            = (ALU_Control_IN == OP_MULT) || (ALU_Control_IN == OP_MULTU) ||
                               (ALU_Control_IN == OP_DIV)  || (ALU_Control_IN == OP_DIVU);
    assign shamt             = SHW'(ShiftAmount_IN);

    assign Out_Valid         = outValid_q;
    assign Instr_OUT         = instr_q;
    assign Instr_PC_OUT      = pc_q;
    assign ALU_result_OUT    = result_q;
    assign WriteRegister_OUT = wreg_q;
    assign MemWriteData_OUT  = memData_q;
    assign RegWrite_OUT      = regWrite_q;
    assign ALU_Control_OUT   = aluCtl_q;
    assign MemRead_OUT       = memRead_q;
    assign MemWrite_OUT      = memWrite_q;

    // Single-cycle ALU result; unknown opcodes fall back to A + B.
    always_comb begin
        aluRes = OperandA_IN + OperandB_IN;
        case (ALU_Control_IN)
            OP_ADD:  aluRes = OperandA_IN + OperandB_IN;
            OP_SUB:  aluRes = OperandA_IN - OperandB_IN;
            OP_AND:  aluRes = OperandA_IN & OperandB_IN;
            OP_OR:   aluRes = OperandA_IN | OperandB_IN;
            OP_XOR:  aluRes = OperandA_IN ^ OperandB_IN;
            OP_NOR:  aluRes = ~(OperandA_IN | OperandB_IN);
            OP_SLT:  aluRes = {{(W-1){1'b0}}, ($signed(OperandA_IN) < $signed(OperandB_IN))};
            OP_SLTU: aluRes = {{(W-1){1'b0}}, (OperandA_IN < OperandB_IN)};
            OP_SLL:  aluRes = OperandB_IN << shamt;
            OP_SRL:  aluRes = OperandB_IN >> shamt;
            OP_SRA:  aluRes = $signed(OperandB_IN) >>> shamt;
            OP_LUI:  aluRes = OperandB_IN << (W/2);
            OP_MFHI: aluRes = hi_q;
            OP_MFLO: aluRes = lo_q;
            OP_MTHI: aluRes = OperandA_IN;
            OP_MTLO: aluRes = OperandA_IN;
            default: aluRes = OperandA_IN + OperandB_IN;
        endcase
    end

    // Operand magnitudes and result-sign flags captured when an MD op starts.
    always_comb begin
        isSignedOp = (ALU_Control_IN == OP_MULT) || (ALU_Control_IN == OP_DIV);
        isDivOp    = (ALU_Control_IN == OP_DIV) || (ALU_Control_IN == OP_DIVU);
        magA       = (isSignedOp && OperandA_IN[W-1]) ? -OperandA_IN : OperandA_IN;
        magB       = (isSignedOp && OperandB_IN[W-1]) ? -OperandB_IN : OperandB_IN;
        negLo      = isSignedOp & (OperandA_IN[W-1] ^ OperandB_IN[W-1]);
        negHi      = isSignedOp & isDivOp & OperandA_IN[W-1];
        divZero    = isDivOp && (OperandB_IN == '0);
    end

    // One radix-2 step (shift-add or restoring divide) plus the sign-corrected
    // final values used on the last iteration.
    always_comb begin
        mulSum   = accLo_q[0] ? (accHi_q + {1'b0, mcand_q}) : accHi_q;
        divShift = {accHi_q[W-1:0], accLo_q[W-1]};
        divTrial = divShift - {1'b0, mcand_q};
        if (isDiv_q) begin
            if (!divTrial[W]) begin
                accHi_d = divTrial;
                accLo_d = {accLo_q[W-2:0], 1'b1};
            end else begin
                accHi_d = divShift;
                accLo_d = {accLo_q[W-2:0], 1'b0};
            end
        end else begin
            accHi_d = {1'b0, mulSum[W:1]};
            accLo_d = {mulSum[0], accLo_q[W-1:1]};
        end
        prodMag = {accHi_d[W-1:0], accLo_d};
        prodRes = negLo_q ? -prodMag : prodMag;
        if (!isDiv_q) begin
            finalHi_d = prodRes[2*W-1:W];
            finalLo_d = prodRes[W-1:0];
        end else if (divZero_q) begin
            finalHi_d = dividend_q;
            finalLo_d = '1;
        end else begin
            finalHi_d = negHi_q ? -accHi_d[W-1:0] : accHi_d[W-1:0];
            finalLo_d = negLo_q ? -accLo_d : accLo_d;
        end
    end

    // Stage control FSM, HI/LO, MD iteration state and the MEM-facing registers.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            accHi_q     <= '0;
            accLo_q     <= '0;
            mcand_q     <= '0;
            isDiv_q     <= 1'b0;
            negLo_q     <= 1'b0;
            negHi_q     <= 1'b0;
            divZero_q   <= 1'b0;
            dividend_q  <= '0;
            bInstr_q    <= '0;
            bPc_q       <= '0;
            bWreg_q     <= '0;
            bMemData_q  <= '0;
            bMemRead_q  <= 1'b0;
            bMemWrite_q <= 1'b0;
            bAluCtl_q   <= '0;
            outValid_q  <= 1'b0;
            instr_q     <= '0;
            pc_q        <= '0;
            result_q    <= '0;
            wreg_q      <= '0;
            memData_q   <= '0;
            regWrite_q  <= 1'b0;
            aluCtl_q    <= '0;
            memRead_q   <= 1'b0;
            memWrite_q  <= 1'b0;
        end else begin
            outValid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (isMdOp) begin
                            state_q     <= BUSY;
                            cnt_q       <= CNT_W'(W);
                            accHi_q     <= '0;
                            accLo_q     <= isDivOp ? magA : magB;
                            mcand_q     <= isDivOp ? magB : magA;
                            isDiv_q     <= isDivOp;
                            negLo_q     <= negLo;
                            negHi_q     <= negHi;
                            divZero_q   <= divZero;
                            dividend_q  <= OperandA_IN;
                            bInstr_q    <= Instr_IN;
                            bPc_q       <= Instr_PC_IN;
                            bWreg_q     <= WriteRegister_IN;
                            bMemData_q  <= MemWriteData_IN;
                            bMemRead_q  <= MemRead_IN;
                            bMemWrite_q <= MemWrite_IN;
                            bAluCtl_q   <= ALU_Control_IN;
                        end else begin
                            outValid_q <= 1'b1;
                            instr_q    <= Instr_IN;
                            pc_q       <= Instr_PC_IN;
                            result_q   <= aluRes;
                            wreg_q     <= WriteRegister_IN;
                            memData_q  <= MemWriteData_IN;
                            regWrite_q <= RegWrite_IN;
                            aluCtl_q   <= ALU_Control_IN;
                            memRead_q  <= MemRead_IN;
                            memWrite_q <= MemWrite_IN;
                            if (ALU_Control_IN == OP_MTHI) begin
                                hi_q <= OperandA_IN;
                            end
                            if (ALU_Control_IN == OP_MTLO) begin
                                lo_q <= OperandA_IN;
                            end
                        end
                    end
                end
                BUSY: begin
                    if (Flush) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        accHi_q <= accHi_d;
                        accLo_q <= accLo_d;
                        cnt_q   <= cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            state_q    <= IDLE;
                            hi_q       <= finalHi_d;
                            lo_q       <= finalLo_d;
                            outValid_q <= 1'b1;
                            instr_q    <= bInstr_q;
                            pc_q       <= bPc_q;
                            result_q   <= finalLo_d;
                            wreg_q     <= bWreg_q;
                            memData_q  <= bMemData_q;
                            regWrite_q <= 1'b0;
                            aluCtl_q   <= bAluCtl_q;
                            memRead_q  <= bMemRead_q;
                            memWrite_q <= bMemWrite_q;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exe_stage_md.sv
// Self-checking bench for exe_stage_md: directed scenarios plus a randomized
// run, all checked against an arithmetic model of HI/LO and the ALU.
module tb_exe_stage_md;

    localparam int W = 32;

    localparam logic [5:0] OP_ADD   = 6'h00;
    localparam logic [5:0] OP_SUB   = 6'h01;
    localparam logic [5:0] OP_AND   = 6'h02;
    localparam logic [5:0] OP_OR    = 6'h03;
    localparam logic [5:0] OP_XOR   = 6'h04;
    localparam logic [5:0] OP_NOR   = 6'h05;
    localparam logic [5:0] OP_SLT   = 6'h06;
    localparam logic [5:0] OP_SLTU  = 6'h07;
    localparam logic [5:0] OP_SLL   = 6'h08;
    localparam logic [5:0] OP_SRL   = 6'h09;
    localparam logic [5:0] OP_SRA   = 6'h0A;
    localparam logic [5:0] OP_LUI   = 6'h0B;
    localparam logic [5:0] OP_MULT  = 6'h10;
    localparam logic [5:0] OP_MULTU = 6'h11;
    localparam logic [5:0] OP_DIV   = 6'h12;
    localparam logic [5:0] OP_DIVU  = 6'h13;
    localparam logic [5:0] OP_MFHI  = 6'h14;
    localparam logic [5:0] OP_MFLO  = 6'h15;
    localparam logic [5:0] OP_MTHI  = 6'h16;
    localparam logic [5:0] OP_MTLO  = 6'h17;

    logic           CLK = 1'b0;
    logic           RESET;
    logic           Flush;
    logic           In_Valid;
    logic           In_Ready;
    logic [31:0]    Instr_IN;
    logic [31:0]    Instr_PC_IN;
    logic [W-1:0]   OperandA_IN;
    logic [W-1:0]   OperandB_IN;
    logic [4:0]     WriteRegister_IN;
    logic [W-1:0]   MemWriteData_IN;
    logic           RegWrite_IN;
    logic           MemRead_IN;
    logic           MemWrite_IN;
    logic [5:0]     ALU_Control_IN;
    logic [4:0]     ShiftAmount_IN;
    logic           Out_Valid;
    logic [31:0]    Instr_OUT;
    logic [31:0]    Instr_PC_OUT;
    logic [W-1:0]   ALU_result_OUT;
    logic [4:0]     WriteRegister_OUT;
    logic [W-1:0]   MemWriteData_OUT;
    logic           RegWrite_OUT;
    logic [5:0]     ALU_Control_OUT;
    logic           MemRead_OUT;
    logic           MemWrite_OUT;
    logic           Busy;

    int vectors = 0;
    int miscompares = 0;

    logic [W-1:0] modelHi;
    logic [W-1:0] modelLo;

    logic [31:0]  curInstr;
    logic [31:0]  curPc;
    logic [4:0]   curWreg;
    logic [W-1:0] curMemData;
    logic         curRw;
    logic         curMr;
    logic         curMw;

    exe_stage_md #(.W(W), .CNT_W(6)) dut (
        .CLK(CLK), .RESET(RESET), .Flush(Flush), .In_Valid(In_Valid), .In_Ready(In_Ready),
        .Instr_IN(Instr_IN), .Instr_PC_IN(Instr_PC_IN),
        .OperandA_IN(OperandA_IN), .OperandB_IN(OperandB_IN),
        .WriteRegister_IN(WriteRegister_IN), .MemWriteData_IN(MemWriteData_IN),
        .RegWrite_IN(RegWrite_IN), .MemRead_IN(MemRead_IN), .MemWrite_IN(MemWrite_IN),
        .ALU_Control_IN(ALU_Control_IN), .ShiftAmount_IN(ShiftAmount_IN),
        .Out_Valid(Out_Valid), .Instr_OUT(Instr_OUT), .Instr_PC_OUT(Instr_PC_OUT),
        .ALU_result_OUT(ALU_result_OUT), .WriteRegister_OUT(WriteRegister_OUT),
        .MemWriteData_OUT(MemWriteData_OUT), .RegWrite_OUT(RegWrite_OUT),
        .ALU_Control_OUT(ALU_Control_OUT), .MemRead_OUT(MemRead_OUT),
        .MemWrite_OUT(MemWrite_OUT), .Busy(Busy)
    );

    always #5 CLK = ~CLK;

    // Reference ALU: what a single-cycle op must produce given the model HI/LO.
    function automatic logic [W-1:0] refSingle(input logic [5:0] op, input logic [W-1:0] a,
                                               input logic [W-1:0] b, input logic [4:0] sa);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_NOR:  return ~(a | b);
            OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
            OP_SLL:  return b << sa;
            OP_SRL:  return b >> sa;
            OP_SRA:  return $signed(b) >>> sa;
            OP_LUI:  return b << 16;
            OP_MFHI: return modelHi;
            OP_MFLO: return modelLo;
            OP_MTHI: return a;
            OP_MTLO: return a;
            default: return a + b;
        endcase
    endfunction

    // Reference HI/LO update using wide integer arithmetic.
    task automatic refMd(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint      la;
        longint      lb;
        longint      q;
        longint      r;
        logic [63:0] p;
        la = $signed(a);
        lb = $signed(b);
        case (op)
            OP_MULT: begin
                p = la * lb;
                modelHi = p[63:32];
                modelLo = p[31:0];
            end
            OP_MULTU: begin
                p = {32'b0, a} * {32'b0, b};
                modelHi = p[63:32];
                modelLo = p[31:0];
            end
            OP_DIV, OP_DIVU: begin
                if (b == 0) begin
                    modelLo = '1;
                    modelHi = a;
                end else if (op == OP_DIV) begin
                    q = la / lb;
                    r = la % lb;
                    modelLo = q[31:0];
                    modelHi = r[31:0];
                end else begin
                    modelLo = a / b;
                    modelHi = a % b;
                end
            end
            OP_MTHI: modelHi = a;
            OP_MTLO: modelLo = a;
            default: ;
        endcase
    endtask

    task automatic randBundle();
        curInstr   = $urandom;
        curPc      = $urandom;
        curWreg    = 5'($urandom_range(1, 31));
        curMemData = $urandom;
        curRw      = 1'($urandom_range(0, 1));
        curMr      = 1'($urandom_range(0, 1));
        curMw      = 1'($urandom_range(0, 1));
    endtask

    // Drives one instruction for exactly one accepting edge.
    task automatic startOp(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [4:0] sa);
        Instr_IN         = curInstr;
        Instr_PC_IN      = curPc;
        WriteRegister_IN = curWreg;
        MemWriteData_IN  = curMemData;
        RegWrite_IN      = curRw;
        MemRead_IN       = curMr;
        MemWrite_IN      = curMw;
        ALU_Control_IN   = op;
        OperandA_IN      = a;
        OperandB_IN      = b;
        ShiftAmount_IN   = sa;
        In_Valid         = 1'b1;
        @(posedge CLK);
        #1;
        In_Valid         = 1'b0;
    endtask

    // Issues an op and waits (bounded) for its Out_Valid pulse.
    task automatic applyStimulus(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [4:0] sa, output int lat, output int lowReady);
        startOp(op, a, b, sa);
        lat = 1;
        lowReady = 0;
        while (Out_Valid !== 1'b1 && lat < W + 8) begin
            if (In_Ready === 1'b0) lowReady++;
            @(posedge CLK);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        int lat;
        int lowReady;
        randBundle();
        applyStimulus(OP_MTHI, 32'hDEAD, 32'h0, 5'd0, lat, lowReady);
        refMd(OP_MTHI, 32'hDEAD, 32'h0);
        applyStimulus(OP_MTLO, 32'hBEEF, 32'h0, 5'd0, lat, lowReady);
        refMd(OP_MTLO, 32'hBEEF, 32'h0);
        randBundle();
        startOp(OP_MULT, 32'h1234_5678, 32'h9, 5'd0);
        repeat (5) @(posedge CLK);
        #2;
        RESET = 1'b0;
        #1;
        modelHi = '0;
        modelLo = '0;
        vectors++;
        if (Out_Valid !== 1'b0 || Busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_valid_busy got valid=%b busy=%b want 0 0", Out_Valid, Busy);
        end
        vectors++;
        if ({Instr_OUT, Instr_PC_OUT, ALU_result_OUT, MemWriteData_OUT} !== 128'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_data got %h %h %h %h want all 0", Instr_OUT, Instr_PC_OUT,
                     ALU_result_OUT, MemWriteData_OUT);
        end
        vectors++;
        if ({WriteRegister_OUT, RegWrite_OUT, ALU_Control_OUT, MemRead_OUT, MemWrite_OUT} !== 14'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_ctrl got wreg=%h rw=%b ctl=%h mr=%b mw=%b want all 0",
                     WriteRegister_OUT, RegWrite_OUT, ALU_Control_OUT, MemRead_OUT, MemWrite_OUT);
        end
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        vectors++;
        if (In_Ready !== 1'b1 || Out_Valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_release got ready=%b valid=%b want 1 0", In_Ready, Out_Valid);
        end
        applyStimulus(OP_MFHI, 32'h0, 32'h0, 5'd0, lat, lowReady);
        vectors++;
        if (ALU_result_OUT !== modelHi) begin
            miscompares++;
            $display("[TB] FAIL reset_hi got %h want %h", ALU_result_OUT, modelHi);
        end
        applyStimulus(OP_MFLO, 32'h0, 32'h0, 5'd0, lat, lowReady);
        vectors++;
        if (ALU_result_OUT !== modelLo) begin
            miscompares++;
            $display("[TB] FAIL reset_lo got %h want %h", ALU_result_OUT, modelLo);
        end
    endtask

    task automatic test_add();
        int lat;
        int lowReady;
        randBundle();
        curWreg = 5'd5;
        curRw   = 1'b1;
        applyStimulus(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0002, 5'd0, lat, lowReady);
        vectors++;
        if (lat != 1 || Out_Valid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL add_latency got lat=%0d valid=%b want 1 1", lat, Out_Valid);
        end
        vectors++;
        if (ALU_result_OUT !== 32'h1 || WriteRegister_OUT !== 5'd5 || RegWrite_OUT !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL add_fields got res=%h wreg=%0d rw=%b want 00000001 5 1",
                     ALU_result_OUT, WriteRegister_OUT, RegWrite_OUT);
        end
        vectors++;
        if (Instr_OUT !== curInstr || Instr_PC_OUT !== curPc || MemWriteData_OUT !== curMemData) begin
            miscompares++;
            $display("[TB] FAIL add_passthru got %h %h %h want %h %h %h", Instr_OUT, Instr_PC_OUT,
                     MemWriteData_OUT, curInstr, curPc, curMemData);
        end
        @(posedge CLK);
        #1;
        vectors++;
        if (Out_Valid !== 1'b0 || ALU_result_OUT !== 32'h1) begin
            miscompares++;
            $display("[TB] FAIL add_hold got valid=%b res=%h want 0 00000001", Out_Valid, ALU_result_OUT);
        end
    endtask

    task automatic test_mult();
        int lat;
        int lowReady;
        randBundle();
        curRw = 1'b1;
        applyStimulus(OP_MULT, 32'hFFFF_FFFE, 32'h0000_0003, 5'd0, lat, lowReady);
        refMd(OP_MULT, 32'hFFFF_FFFE, 32'h0000_0003);
        vectors++;
        if (lat != W + 1 || lowReady != W) begin
            miscompares++;
            $display("[TB] FAIL mult_timing got lat=%0d readyLow=%0d want %0d %0d", lat, lowReady, W + 1, W);
        end
        vectors++;
        if (ALU_result_OUT !== 32'hFFFF_FFFA || RegWrite_OUT !== 1'b0 || WriteRegister_OUT !== curWreg) begin
            miscompares++;
            $display("[TB] FAIL mult_emit got res=%h rw=%b wreg=%0d want fffffffa 0 %0d",
                     ALU_result_OUT, RegWrite_OUT, WriteRegister_OUT, curWreg);
        end
        applyStimulus(OP_MFHI, 32'h0, 32'h0, 5'd0, lat, lowReady);
        vectors++;
        if (ALU_result_OUT !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("[TB] FAIL mult_hi got %h want ffffffff", ALU_result_OUT);
        end
        applyStimulus(OP_MFLO, 32'h0, 32'h0, 5'd0, lat, lowReady);
        vectors++;
        if (ALU_result_OUT !== 32'hFFFF_FFFA) begin
            miscompares++;
            $display("[TB] FAIL mult_lo got %h want fffffffa", ALU_result_OUT);
        end
    endtask

    task automatic test_div();
        int lat;
        int lowReady;
        randBundle();
        applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'h2, 5'd0, lat, lowReady);
        refMd(OP_DIV, 32'hFFFF_FFF9, 32'h2);
        vectors++;
        if (ALU_result_OUT !== 32'hFFFF_FFFD || lat != W + 1) begin
            miscompares++;
            $display("[TB] FAIL div_lo got %h lat=%0d want fffffffd %0d", ALU_result_OUT, lat, W + 1);
        end
        applyStimulus(OP_MFHI, 32'h0, 32'h0, 5'd0, lat, lowReady);
        vectors++;
        if (ALU_result_OUT !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("[TB] FAIL div_hi got %h want ffffffff", ALU_result_OUT);
        end
        applyStimulus(OP_DIVU, 32'h7, 32'h0, 5'd0, lat, lowReady);
        refMd(OP_DIVU, 32'h7, 32'h0);
        vectors++;
        if (ALU_result_OUT !== 32'hFFFF_FFFF || lat != W + 1) begin
            miscompares++;
            $display("[TB] FAIL divzero_lo got %h lat=%0d want ffffffff %0d", ALU_result_OUT, lat, W + 1);
        end
        applyStimulus(OP_MFHI, 32'h0, 32'h0, 5'd0, lat, lowReady);
        vectors++;
        if (ALU_result_OUT !== 32'h7) begin
            miscompares++;
            $display("[TB] FAIL divzero_hi got %h want 00000007", ALU_result_OUT);
        end
        applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, lat, lowReady);
        refMd(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        vectors++;
        if (ALU_result_OUT !== 32'h8000_0000) begin
            miscompares++;
            $display("[TB] FAIL divovf_lo got %h want 80000000", ALU_result_OUT);
        end
        applyStimulus(OP_MFHI, 32'h0, 32'h0, 5'd0, lat, lowReady);
        vectors++;
        if (ALU_result_OUT !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL divovf_hi got %h want 00000000", ALU_result_OUT);
        end
    endtask

    task automatic test_flush();
        int lat;
        int lowReady;
        int pulses;
        randBundle();
        applyStimulus(OP_MTHI, 32'h1234, 32'h0, 5'd0, lat, lowReady);
        refMd(OP_MTHI, 32'h1234, 32'h0);
        startOp(OP_MULTU, 32'h5, 32'h6, 5'd0);
        vectors++;
        if (Busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL flush_busy_start got %b want 1", Busy);
        end
        repeat (9) begin
            @(posedge CLK);
            #1;
        end
        Flush = 1'b1;
        @(posedge CLK);
        #1;
        Flush = 1'b0;
        vectors++;
        if (Busy !== 1'b0 || Out_Valid !== 1'b0 || In_Ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL flush_abort got busy=%b valid=%b ready=%b want 0 0 1", Busy, Out_Valid, In_Ready);
        end
        pulses = 0;
        repeat (W + 2) begin
            @(posedge CLK);
            #1;
            if (Out_Valid === 1'b1) pulses++;
        end
        vectors++;
        if (pulses != 0) begin
            miscompares++;
            $display("[TB] FAIL flush_no_pulse got %0d pulses want 0", pulses);
        end
        applyStimulus(OP_MFHI, 32'h0, 32'h0, 5'd0, lat, lowReady);
        vectors++;
        if (ALU_result_OUT !== 32'h1234) begin
            miscompares++;
            $display("[TB] FAIL flush_hi got %h want 00001234", ALU_result_OUT);
        end
        applyStimulus(OP_MFLO, 32'h0, 32'h0, 5'd0, lat, lowReady);
        vectors++;
        if (ALU_result_OUT !== modelLo) begin
            miscompares++;
            $display("[TB] FAIL flush_lo got %h want %h", ALU_result_OUT, modelLo);
        end
        startOp(OP_MULTU, 32'h7, 32'h9, 5'd0);
        repeat (W - 1) begin
            @(posedge CLK);
            #1;
        end
        Flush = 1'b1;
        @(posedge CLK);
        #1;
        Flush = 1'b0;
        vectors++;
        if (Out_Valid !== 1'b0 || Busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL flush_priority got valid=%b busy=%b want 0 0", Out_Valid, Busy);
        end
        applyStimulus(OP_MFLO, 32'h0, 32'h0, 5'd0, lat, lowReady);
        vectors++;
        if (ALU_result_OUT !== modelLo) begin
            miscompares++;
            $display("[TB] FAIL flush_priority_lo got %h want %h", ALU_result_OUT, modelLo);
        end
        Flush = 1'b1;
        startOp(OP_MTLO, 32'h5555, 32'h0, 5'd0);
        Flush = 1'b0;
        vectors++;
        if (Out_Valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL flush_idle got valid=%b want 0", Out_Valid);
        end
        applyStimulus(OP_MFLO, 32'h0, 32'h0, 5'd0, lat, lowReady);
        vectors++;
        if (ALU_result_OUT !== modelLo) begin
            miscompares++;
            $display("[TB] FAIL flush_idle_lo got %h want %h", ALU_result_OUT, modelLo);
        end
    endtask

    task automatic test_shifts();
        int lat;
        int lowReady;
        randBundle();
        applyStimulus(OP_SRA, 32'h0, 32'h8000_0000, 5'd4, lat, lowReady);
        vectors++;
        if (ALU_result_OUT !== 32'hF800_0000) begin
            miscompares++;
            $display("[TB] FAIL sra got %h want f8000000", ALU_result_OUT);
        end
        applyStimulus(OP_SLTU, 32'h1, 32'hFFFF_FFFF, 5'd0, lat, lowReady);
        vectors++;
        if (ALU_result_OUT !== 32'h1) begin
            miscompares++;
            $display("[TB] FAIL sltu got %h want 00000001", ALU_result_OUT);
        end
        applyStimulus(OP_SLT, 32'h1, 32'hFFFF_FFFF, 5'd0, lat, lowReady);
        vectors++;
        if (ALU_result_OUT !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL slt got %h want 00000000", ALU_result_OUT);
        end
        applyStimulus(OP_LUI, 32'h0, 32'h0000_1234, 5'd0, lat, lowReady);
        vectors++;
        if (ALU_result_OUT !== 32'h1234_0000) begin
            miscompares++;
            $display("[TB] FAIL lui got %h want 12340000", ALU_result_OUT);
        end
    endtask

    task automatic checkOutput(input logic [5:0] op, input logic [W-1:0] expRes, input int lat,
                               input int lowReady);
        logic isMd;
        isMd = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
        vectors++;
        if (lat != (isMd ? W + 1 : 1) || lowReady != (isMd ? W : 0)) begin
            miscompares++;
            $display("[TB] FAIL rand_timing op=%h got lat=%0d readyLow=%0d", op, lat, lowReady);
        end
        if (op != OP_MTHI && op != OP_MTLO) begin
            vectors++;
            if (ALU_result_OUT !== expRes) begin
                miscompares++;
                $display("[TB] FAIL rand_result op=%h got %h want %h", op, ALU_result_OUT, expRes);
            end
        end
        vectors++;
        if (RegWrite_OUT !== (isMd ? 1'b0 : curRw) || WriteRegister_OUT !== curWreg ||
            Instr_OUT !== curInstr || Instr_PC_OUT !== curPc || MemWriteData_OUT !== curMemData ||
            ALU_Control_OUT !== op || MemRead_OUT !== curMr || MemWrite_OUT !== curMw) begin
            miscompares++;
            $display("[TB] FAIL rand_bundle op=%h got rw=%b wreg=%0d instr=%h ctl=%h", op,
                     RegWrite_OUT, WriteRegister_OUT, Instr_OUT, ALU_Control_OUT);
        end
    endtask

    task automatic test_random();
        logic [5:0]   opList [22];
        logic [W-1:0] specials [6];
        logic [5:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [4:0]   sa;
        logic [W-1:0] expRes;
        int           lat;
        int           lowReady;
        opList = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU, OP_SLL, OP_SRL,
                   OP_SRA, OP_LUI, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MFHI, OP_MFLO, OP_MTHI,
                   OP_MTLO, 6'h0C, 6'h3F};
        specials = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0003};
        for (int i = 0; i < 70; i++) begin
            randBundle();
            op = opList[$urandom_range(0, 21)];
            a  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : 32'($urandom);
            b  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : 32'($urandom);
            if ((op == OP_DIV || op == OP_DIVU) && $urandom_range(0, 1) == 1) begin
                b = 32'($urandom_range(0, 20)) - 32'd10;
            end
            sa = 5'($urandom);
            if (op == OP_MULT || op == OP_MULTU || op == OP_DIV || op == OP_DIVU) begin
                refMd(op, a, b);
                expRes = modelLo;
            end else begin
                expRes = refSingle(op, a, b, sa);
                refMd(op, a, b);
            end
            applyStimulus(op, a, b, sa, lat, lowReady);
            checkOutput(op, expRes, lat, lowReady);
            @(posedge CLK);
            #1;
            if (op != OP_MTHI && op != OP_MTLO) begin
                vectors++;
                if (Out_Valid !== 1'b0 || ALU_result_OUT !== expRes) begin
                    miscompares++;
                    $display("[TB] FAIL rand_hold op=%h got valid=%b res=%h want 0 %h", op,
                             Out_Valid, ALU_result_OUT, expRes);
                end
            end
        end
    endtask

    initial begin
        RESET            = 1'b0;
        Flush            = 1'b0;
        In_Valid         = 1'b0;
        Instr_IN         = '0;
        Instr_PC_IN      = '0;
        OperandA_IN      = '0;
        OperandB_IN      = '0;
        WriteRegister_IN = '0;
        MemWriteData_IN  = '0;
        RegWrite_IN      = 1'b0;
        MemRead_IN       = 1'b0;
        MemWrite_IN      = 1'b0;
        ALU_Control_IN   = '0;
        ShiftAmount_IN   = '0;
        modelHi          = '0;
        modelLo          = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        test_reset();
        test_add();
        test_mult();
        test_div();
        test_flush();
        test_shifts();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
